// File: rtl/i2s_frame_capture.sv
// I2S MEMS microphone front end: BCLK/LRCLK generation, one-channel capture,
// FRAME_LEN-sample framing with valid/ready handoff. Optional macro: OVERLAP_EN.
module i2s_frame_capture #(
    parameter int SAMPLE_W  = 16,
    parameter int SLOT_W    = 32,
    parameter int FRAME_LEN = 16,
    parameter int BCLK_DIV  = 8,
    parameter int CHANNEL   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          DOUT,
    output logic                          BCLK,
    output logic                          LRCLK,
    output logic [FRAME_LEN*SAMPLE_W-1:0] frame_data,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic [7:0]                    overrun_cnt
);

    localparam int FRAME_W = FRAME_LEN * SAMPLE_W;
    localparam int DW      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BW      = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam int FW      = $clog2(FRAME_LEN + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_W - 1);
    localparam logic [BW-1:0] BIT_LSB   = BW'(SAMPLE_W);
    localparam logic [FW-1:0] FILL_LAST = FW'(FRAME_LEN - 1);
    localparam logic          CH_SEL    = (CHANNEL != 0);

`ifdef OVERLAP_EN
    // Keep the newer half of the window so the next frame needs half as many samples.
    localparam logic [FW-1:0] FILL_RELOAD = FW'(FRAME_LEN / 2);
`else
    localparam logic [FW-1:0] FILL_RELOAD = '0;
`endif

    logic                dout_s1_q;
    logic                dout_s2_q;

    logic [DW-1:0]       div_cnt_q, div_cnt_d;
    logic                bclk_q, bclk_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                lrclk_q, lrclk_d;

    logic                rise_p1_q;
    logic                rise_p2_q;

    logic [SAMPLE_W-2:0] shift_q, shift_d;
    logic [FRAME_W-1:0]  win_q, win_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic                done_q, done_d;

    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic                valid_q, valid_d;
    logic [7:0]          ovr_q, ovr_d;

    logic                div_wrap;
    logic                bclk_rise;
    logic                bclk_fall;
    logic                bit_wrap;
    logic                cap_en;
    logic                commit;
    logic [SAMPLE_W-1:0] word;

    assign div_wrap  = (div_cnt_q == DIV_LAST);
    assign bclk_rise = div_wrap & ~bclk_q;
    assign bclk_fall = div_wrap & bclk_q;
    assign bit_wrap  = (bit_cnt_q == BIT_LAST);

    // The capture point trails the bus rising edge by the two sync stages.
    // bit_cnt/LRCLK only move on a falling toggle, at least two clk later,
    // so their current values still describe the bit being captured.
    assign cap_en = rise_p2_q
                  && (lrclk_q == CH_SEL)
                  && (bit_cnt_q != '0)
                  && (bit_cnt_q <= BIT_LSB);
    assign commit = cap_en && (bit_cnt_q == BIT_LSB);
    assign word   = {shift_q, dout_s2_q};

    // Two-flop synchroniser for the mic data line.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_s1_q <= 1'b0;
            dout_s2_q <= 1'b0;
        end else begin
            dout_s1_q <= DOUT;
            dout_s2_q <= dout_s1_q;
        end
    end

    // Bus clock next state: divider, BCLK toggle, bit position and word select.
    always_comb begin
        div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
        bclk_d    = bclk_q;
        bit_cnt_d = bit_cnt_q;
        lrclk_d   = lrclk_q;
        if (div_wrap) begin
            bclk_d = ~bclk_q;
        end
        if (bclk_fall) begin
            bit_cnt_d = bit_wrap ? '0 : bit_cnt_q + 1'b1;
            if (bit_wrap) begin
                lrclk_d = ~lrclk_q;
            end
        end
    end

    // Bus clock state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '0;
            lrclk_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
            lrclk_q   <= lrclk_d;
        end
    end

    // Delay the rising-edge strobe to line up with the synchronised data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_p1_q <= 1'b0;
            rise_p2_q <= 1'b0;
        end else begin
            rise_p1_q <= bclk_rise;
            rise_p2_q <= rise_p1_q;
        end
    end

    // Capture next state: bit shifting, sample window and fill accounting.
    always_comb begin
        shift_d = shift_q;
        win_d   = win_q;
        fill_d  = fill_q;
        done_d  = 1'b0;
        if (cap_en) begin
            shift_d = word[SAMPLE_W-2:0];
        end
        if (commit) begin
            win_d = {word, win_q[FRAME_W-1:SAMPLE_W]};
            if (fill_q == FILL_LAST) begin
                fill_d = FILL_RELOAD;
                done_d = 1'b1;
            end else begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // Capture state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            win_q   <= '0;
            fill_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            done_q  <= done_d;
        end
    end

    // Output handoff: load when the slot is free or being emptied, else drop.
    always_comb begin
        frame_d = frame_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (done_q) begin
            if (!valid_q || frame_ready) begin
                frame_d = win_q;
                valid_d = 1'b1;
            end else if (ovr_q != 8'hFF) begin
                ovr_d = ovr_q + 8'd1;
            end
        end else if (valid_q && frame_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= '0;
        end else begin
            frame_q <= frame_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign BCLK        = bclk_q;
    assign LRCLK       = lrclk_q;
    assign frame_data  = frame_q;
    assign frame_valid = valid_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_i2s_frame_capture.sv
// Bench for i2s_frame_capture: behavioural I2S mic, directed frame tables,
// handshake/backpressure/reset sequences and a small instance for saturation.
module tb_i2s_frame_capture;

    localparam int SW = 16;
    localparam int FL = 16;
    localparam int FW = FL * SW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          DOUT = 1'b0;
    logic          BCLK;
    logic          LRCLK;
    logic [FW-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ready = 1'b0;
    logic [7:0]    overrun_cnt;

    logic          rst2 = 1'b1;
    logic          ready2 = 1'b0;
    logic          bclk2;
    logic          lrclk2;
    logic [3:0]    data2;
    logic          valid2;
    logic [7:0]    ovr2;

    int            n_checks = 0;
    int            n_fail = 0;

    logic [15:0]   samp_tab [0:63];
    logic [15:0]   trail = 16'h0000;
    logic          dly = 1'b0;

    always #5 clk = ~clk;

    i2s_frame_capture #(
        .SAMPLE_W(16), .SLOT_W(32), .FRAME_LEN(16),
        .BCLK_DIV(2), .CHANNEL(0)
    ) dut (
        .clk(clk), .rst(rst), .DOUT(DOUT),
        .BCLK(BCLK), .LRCLK(LRCLK),
        .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .overrun_cnt(overrun_cnt)
    );

    i2s_frame_capture #(
        .SAMPLE_W(2), .SLOT_W(3), .FRAME_LEN(2),
        .BCLK_DIV(2), .CHANNEL(0)
    ) dut_small (
        .clk(clk), .rst(rst2), .DOUT(DOUT),
        .BCLK(bclk2), .LRCLK(lrclk2),
        .frame_data(data2), .frame_valid(valid2),
        .frame_ready(ready2), .overrun_cnt(ovr2)
    );

    task automatic check(input string nm, input logic [FW-1:0] act,
                         input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] ramp(input logic [15:0] first);
        logic [FW-1:0] r;
        r = '0;
        for (int i = 0; i < FL; i++) r[i*SW +: SW] = first + 16'(i);
        return r;
    endfunction

    // Mic model: slot word is {sample, trail}; right slots drive all ones.
    function automatic logic bitval(input int slot, input int pos);
        logic [31:0] w;
        if (slot[0]) return 1'b1;
        if (pos == 0) return dly;
        if (pos > 31) return 1'b0;
        w = {samp_tab[(slot >> 1) & 63], trail};
        return w[32 - pos];
    endfunction

    initial begin : mic
        int   slot;
        int   pos;
        logic pb;
        logic pl;
        slot = 0;
        pos = 0;
        pb = 1'b0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                slot = 0;
                pos = 0;
                DOUT = bitval(0, 0);
            end else if (pb && !BCLK) begin
                if (LRCLK != pl) begin
                    slot++;
                    pos = 0;
                end else begin
                    pos++;
                end
                DOUT = bitval(slot, pos);
            end
            pb = BCLK;
            pl = LRCLK;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_valid(input int lim, input string nm, output int cyc);
        bit ok;
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            #1;
            cyc = i + 1;
            if (frame_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({nm, "_timeout"}, frame_valid, 1);
    endtask

    typedef struct {
        string       name;
        logic [15:0] first;
    } fvec_t;

    fvec_t vecs[$];

    initial begin : main
        int            cyc;
        logic [FW-1:0] expb;
        logic [FW-1:0] snap;
        bit            stable;
        bit            saw;

        vecs.push_back('{"A_f0", 16'h0001});
`ifdef OVERLAP_EN
        vecs.push_back('{"A_f1", 16'h0009});
        vecs.push_back('{"A_f2", 16'h0011});
`else
        vecs.push_back('{"A_f1", 16'h0011});
`endif

        for (int n = 0; n < 64; n++) samp_tab[n] = 16'(n + 1);

        // Reset values and bus clock timing.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bclk", BCLK, 0);
        check("rst_lrclk", LRCLK, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_ovr", overrun_cnt, 0);
        check("rst_data", frame_data, 0);
        rst = 1'b0;
        for (int c = 1; c <= 256; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) check("bclk_e1", BCLK, 0);
            if (c == 2) check("bclk_e2", BCLK, 1);
            if (c == 4) check("bclk_e4", BCLK, 0);
            if (c == 6) check("bclk_e6", BCLK, 1);
            if (c == 127) check("lr_e127", LRCLK, 0);
            if (c == 128) check("lr_e128", LRCLK, 1);
            if (c == 255) check("lr_e255", LRCLK, 1);
            if (c == 256) check("lr_e256", LRCLK, 0);
        end

        // Streaming frames with ready held high.
        frame_ready = 1'b1;
        do_reset();
        foreach (vecs[k]) begin
            wait_valid(5000, vecs[k].name, cyc);
            check(vecs[k].name, frame_data, ramp(vecs[k].first));
            @(posedge clk);
            #1;
            check({vecs[k].name, "_1cyc"}, frame_valid, 0);
        end

        // Delay bit high, trailing ones, extreme words.
        for (int n = 0; n < 64; n++) samp_tab[n] = 16'h1000 + 16'(n);
        samp_tab[0] = 16'h8000;
        samp_tab[1] = 16'h7FFF;
        dly = 1'b1;
        trail = 16'hFFFF;
        do_reset();
        wait_valid(5000, "B", cyc);
        expb = ramp(16'h1000);
        expb[15:0] = 16'h8000;
        expb[31:16] = 16'h7FFF;
        check("B_msb", frame_data[15:0], 16'h8000);
        check("B_lsb", frame_data[31:16], 16'h7FFF);
        check("B_frame", frame_data, expb);

        // Backpressure: first frame held, second dropped.
        dly = 1'b0;
        trail = 16'h0000;
        for (int n = 0; n < 64; n++) samp_tab[n] = 16'h0300 + 16'(n);
        frame_ready = 1'b0;
        do_reset();
        wait_valid(5000, "C_first", cyc);
        check("C_first", frame_data, ramp(16'h0300));
        snap = frame_data;
        stable = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            if (frame_data !== snap || !frame_valid) stable = 1'b0;
            if (overrun_cnt != 8'd0) break;
        end
        check("C_stable", stable, 1);
        check("C_ovr1", overrun_cnt, 1);
        check("C_held", frame_data, ramp(16'h0300));
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        check("C_drop", frame_valid, 0);
        check("C_ovr_keep", overrun_cnt, 1);

        // Reset after 7 committed samples discards the partial frame.
        for (int n = 0; n < 64; n++) samp_tab[n] = 16'h0400 + 16'(n);
        do_reset();
        saw = 1'b0;
        repeat (1700) begin
            @(posedge clk);
            #1;
            if (frame_valid) saw = 1'b1;
        end
        check("D_no_early", saw, 0);
        rst = 1'b1;
        for (int n = 0; n < 64; n++) samp_tab[n] = 16'h0500 + 16'(n);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_valid(5000, "D", cyc);
        check("D_late", cyc > 3800, 1);
        check("D_frame", frame_data, ramp(16'h0500));

        // Small instance has been dropping frames since the start.
        check("E_sat", ovr2, 8'd255);
        check("E_valid", valid2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin : small_rst
        repeat (3) @(posedge clk);
        #1 rst2 = 1'b0;
    end

endmodule
